// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Tick timebase: counts 0..DIV-1 and pulses tick on the last count.
module led_prescaler #(
  parameter int DIV = 4194304
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // clr wins over hold so a mode change always restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/led_pattern.sv
// LED pattern generator: OFF / binary COUNT / bouncing SCAN / PWM BREATHE,
// advancing once per prescaler tick, with a registered LED output.
module led_pattern
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int DIV    = 4194304,
  parameter int PWM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              hold,
  output logic [N_LEDS-1:0] leds,
  output logic              tick
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0]     POS_LAST = PW'(N_LEDS - 1);
  localparam logic [PWM_W-1:0]  DUTY_MAX = '1;
  localparam logic [N_LEDS-1:0] ONE      = N_LEDS'(1);

  mode_e             mode_q;
  logic              mode_chg;
  logic [N_LEDS-1:0] count;
  logic [PW-1:0]     pos;
  logic              pos_down;
  logic [PWM_W-1:0]  duty;
  logic              duty_down;
  logic [PWM_W-1:0]  pwm_cnt;

  assign mode_chg = (mode_e'(mode) != mode_q);

  led_prescaler #(
    .DIV(DIV)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mode_chg),
    .hold (hold),
    .tick (tick)
  );

  // Free-running: unaffected by hold and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      count     <= '0;
      pos       <= '0;
      pos_down  <= 1'b0;
      duty      <= '0;
      duty_down <= 1'b0;
      leds      <= '0;
    end else begin
      // leds reflects the state held before this edge: one cycle of latency
      unique case (mode_q)
        MODE_COUNT:   leds <= count;
        MODE_SCAN:    leds <= ONE << pos;
        MODE_BREATHE: leds <= {N_LEDS{pwm_cnt < duty}};
        default:      leds <= '0;
      endcase

      if (mode_chg) begin
        mode_q    <= mode_e'(mode);
        count     <= '0;
        pos       <= '0;
        pos_down  <= 1'b0;
        duty      <= '0;
        duty_down <= 1'b0;
      end else if (tick) begin
        unique case (mode_q)
          MODE_COUNT: count <= count + 1'b1;
          MODE_SCAN: begin
            if (!pos_down) begin
              if (pos == POS_LAST) begin
                pos      <= pos - 1'b1;
                pos_down <= 1'b1;
              end else begin
                pos <= pos + 1'b1;
              end
            end else if (pos == '0) begin
              pos      <= pos + 1'b1;
              pos_down <= 1'b0;
            end else begin
              pos <= pos - 1'b1;
            end
          end
          MODE_BREATHE: begin
            if (!duty_down) begin
              if (duty == DUTY_MAX) begin
                duty      <= duty - 1'b1;
                duty_down <= 1'b1;
              end else begin
                duty <= duty + 1'b1;
              end
            end else if (duty == '0) begin
              duty      <= duty + 1'b1;
              duty_down <= 1'b0;
            end else begin
              duty <= duty - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern.sv
// Bench for led_pattern: vector table, hand-written corner sequences and a
// randomized run checked every cycle against a tick-count reference model.
module tb_led_pattern;

  localparam int N = 4;
  localparam int D = 4;
  localparam int P = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold  = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic [3:0] leds;
  logic       tick;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  led_pattern #(.N_LEDS(N), .DIV(D), .PWM_W(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .hold (hold),
    .leds (leds),
    .tick (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: pattern as a closed-form function of ticks seen since the
  // last mode change and cycles since reset.
  int         m_phase = 0;
  int         m_ticks = 0;
  int         m_cyc   = 0;
  logic [1:0] m_mode  = 2'd0;
  logic [3:0] m_leds  = 4'd0;

  function automatic logic [3:0] pattern(input logic [1:0] md, input int t, input int cyc);
    int p, pos, d, duty;
    case (md)
      2'd1: return 4'(t % (1 << N));
      2'd2: begin
        p   = t % (2 * (N - 1));
        pos = (p < N) ? p : 2 * (N - 1) - p;
        return 4'(1 << pos);
      end
      2'd3: begin
        d    = t % (2 * ((1 << P) - 1));
        duty = (d <= (1 << P) - 1) ? d : 2 * ((1 << P) - 1) - d;
        return ((cyc % (1 << P)) < duty) ? 4'hF : 4'h0;
      end
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_ticks <= 0;
      m_cyc   <= 0;
      m_mode  <= 2'd0;
      m_leds  <= 4'd0;
    end else begin
      m_leds <= pattern(m_mode, m_ticks, m_cyc);
      m_cyc  <= m_cyc + 1;
      if (mode != m_mode) begin
        m_mode  <= mode;
        m_phase <= 0;
        m_ticks <= 0;
      end else if (!hold) begin
        m_phase <= (m_phase + 1) % D;
        if (m_phase == D - 1) m_ticks <= m_ticks + 1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en && rst_n) begin
      check("model_leds", 32'(leds), 32'(m_leds));
      check("model_tick", 32'(tick), 32'(!hold && m_phase == D - 1));
    end
  end

  // Returns at the negedge just after the edge that consumed the n-th tick.
  task automatic wait_ticks(input int n);
    int left = n;
    int g = 0;
    while (left > 0 && g < 200) begin
      @(negedge clk);
      g++;
      if (tick) left--;
    end
    if (left > 0) check("tick_timeout", 32'(left), 32'd0);
    @(negedge clk);
  endtask

  // Freezes the ramp and counts lit cycles over one full PWM period.
  task automatic measure_duty(input string name, input int exp);
    int hi = 0;
    int mixed = 0;
    hold = 1'b1;
    repeat (1 << P) begin
      @(negedge clk);
      if (leds == 4'hF) hi++;
      else if (leds != 4'h0) mixed++;
    end
    hold = 1'b0;
    check({name, "_lit"}, 32'(hi), 32'(exp));
    check({name, "_uniform"}, 32'(mixed), 32'd0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         waits;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] scan_seq[8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0010, 4'b0100};
  int         n;
  logic [3:0] prev;

  initial begin
    tbl.push_back('{2'd1, 2, 4'd0});
    for (int k = 1; k <= 17; k++) tbl.push_back('{2'd1, D, 4'(k % 16)});
    tbl.push_back('{2'd2, 2, 4'b0001});
    for (int k = 0; k < 8; k++) tbl.push_back('{2'd2, D, scan_seq[k]});

    // Power-on reset and first tick
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_leds", 32'(leds), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    n = 1;
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_tick_cycle", 32'(n), 32'd4);

    // COUNT wrap and SCAN bounce
    for (int i = 0; i < tbl.size(); i++) begin
      mode = tbl[i].mode;
      repeat (tbl[i].waits) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(leds), 32'(tbl[i].exp));
    end

    // BREATHE ramp
    mode = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("breathe_start", 32'(leds), 32'd0);
    wait_ticks(3);
    measure_duty("duty3", 3);
    wait_ticks(4);
    measure_duty("duty_peak", 7);
    wait_ticks(7);
    measure_duty("duty_back", 0);

    // Hold in COUNT
    mode = 2'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wait_ticks(2);
    hold = 1'b1;
    @(negedge clk);
    check("hold_leds", 32'(leds), 32'd2);
    check("hold_tick", 32'(tick), 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("hold_leds_%0d", i), 32'(leds), 32'd2);
      check($sformatf("hold_tick_%0d", i), 32'(tick), 32'd0);
    end
    hold = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 30);
    check("tick_after_hold", 32'(n), 32'd3);

    // Mode change on the tick cycle
    prev = leds;
    mode = 2'd2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("chg_no_advance", 32'(leds), 32'(prev));
      if (n == 2) check("chg_scan_first", 32'(leds), 32'b0001);
    end while (!tick && n < 30);
    check("chg_tick_delay", 32'(n), 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("chg_scan_next", 32'(leds), 32'b0010);

    // Asynchronous reset mid-pattern
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    mode = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 1;
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_tick_cycle", 32'(n), 32'd4);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(47) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) hold = ~hold;
      if ($urandom_range(699) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    hold = 1'b0;
    @(negedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
